softex_slot_sched: RTL

SOFTEX_SLOT_SCHED -- requirements
Module: softex_slot_sched

---
 rtl/softex_slot_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/softex_slot_sched.sv
// Slot scheduler: arbitrates ALLOC/LOAD requests and UPDATE/FREE operations
// over a bank of per-slot valid bits, with registered responses and occupancy.
module softex_slot_sched #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned N_SLOTS        = 4,
  parameter int unsigned SLOT_ADDR_BITS = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ-1:0]                req_op_i,
  input  logic [N_REQ*SLOT_ADDR_BITS-1:0] req_addr_i,
  input  logic                            upd_valid_i,
  output logic                            upd_ready_o,
  input  logic                            upd_op_i,
  input  logic [SLOT_ADDR_BITS-1:0]       upd_addr_i,
  output logic [N_REQ-1:0]                rsp_valid_o,
  output logic                            rsp_hit_o,
  output logic                            rsp_err_o,
  output logic [SLOT_ADDR_BITS-1:0]       rsp_addr_o,
  output logic                            mem_we_o,
  output logic [SLOT_ADDR_BITS-1:0]       mem_addr_o,
  output logic [$clog2(N_SLOTS+1)-1:0]    occupancy_o,
  output logic                            full_o
);

  localparam int unsigned AW    = SLOT_ADDR_BITS;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OCC_W = $clog2(N_SLOTS + 1);

  logic [N_SLOTS-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_err_q, rsp_err_d;
  logic [AW-1:0]      rsp_addr_q, rsp_addr_d;

  logic               upd_fire;
  logic               upd_hit;
  logic               upd_in_range;
  logic [N_REQ-1:0]   gnt_oh;
  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_op;
  logic [AW-1:0]      gnt_addr;
  logic               free_found;
  logic [N_SLOTS-1:0] free_oh;
  logic [AW-1:0]      free_idx;

  // Valid bit of an addressed slot; out-of-range addresses read as invalid.
  function automatic logic slot_valid(input logic [N_SLOTS-1:0] v, input logic [AW-1:0] a);
    slot_valid = 1'b0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (a == AW'(s)) slot_valid = v[s];
    end
  endfunction

  // Update port: always accepted unless a clear is in progress; writes go straight to storage.
  always_comb begin
    upd_ready_o  = !clear_i;
    upd_fire     = upd_valid_i && !clear_i;
    upd_hit      = slot_valid(valid_q, upd_addr_i);
    upd_in_range = (32'(upd_addr_i) < N_SLOTS);
    mem_we_o     = upd_fire && !upd_op_i && upd_hit;
    mem_addr_o   = upd_addr_i;
  end

  // Round-robin request arbiter starting at ptr_q; blocked by clear or a firing update.
  always_comb begin
    gnt_oh    = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_op    = 1'b0;
    gnt_addr  = '0;
    if (!clear_i && !upd_fire) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        for (int unsigned j = 0; j < N_REQ; j++) begin
          if (!gnt_found && req_valid_i[j] && (((32'(ptr_q) + i) % N_REQ) == j)) begin
            gnt_found = 1'b1;
            gnt_oh[j] = 1'b1;
            gnt_idx   = PTR_W'(j);
            gnt_op    = req_op_i[j];
            gnt_addr  = req_addr_i[j*AW +: AW];
          end
        end
      end
    end
    req_ready_o = gnt_oh;
  end

  // Lowest-index free slot for ALLOC.
  always_comb begin
    free_found = 1'b0;
    free_oh    = '0;
    free_idx   = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (!free_found && !valid_q[s]) begin
        free_found = 1'b1;
        free_oh[s] = 1'b1;
        free_idx   = AW'(s);
      end
    end
  end

  // Next-state: clear beats update beats granted request; response payload built here.
  always_comb begin
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    rsp_hit_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_addr_d  = '0;
    if (clear_i) begin
      valid_d = '0;
    end else if (upd_fire) begin
      if (upd_op_i && upd_in_range) begin
        for (int unsigned s = 0; s < N_SLOTS; s++) begin
          if (upd_addr_i == AW'(s)) valid_d[s] = 1'b0;
        end
      end
    end else if (gnt_found) begin
      rsp_valid_d = gnt_oh;
      ptr_d       = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      if (!gnt_op) begin
        if (free_found) begin
          valid_d    = valid_q | free_oh;
          rsp_hit_d  = 1'b1;
          rsp_addr_d = free_idx;
        end else begin
          rsp_err_d  = 1'b1;
        end
      end else begin
        rsp_hit_d  = slot_valid(valid_q, gnt_addr);
        rsp_err_d  = (32'(gnt_addr) >= N_SLOTS);
        rsp_addr_d = gnt_addr;
      end
    end
    occ_d = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      occ_d = occ_d + OCC_W'(valid_d[s]);
    end
  end

  // State and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      ptr_q       <= '0;
      occ_q       <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_addr_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      occ_q       <= occ_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign occupancy_o = occ_q;
  assign full_o      = (32'(occ_q) == N_SLOTS);

endmodule
